booth_mult_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer that shares one sequential Booth multiplier among NREQ requesters.

---
 rtl/booth_mult_arbiter.sv | 152 +++++++++++++++
 tb/tb_booth_mult_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_arbiter.sv
// Round-robin sequencer sharing one sequential Booth multiplier among NREQ requesters,
// with start/ready handshake, per-requester done pulses and a timeout abort path.
module booth_mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 6,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   x_in,
    input  logic [NREQ*WIDTH-1:0]   y_in,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic                    err,
    output logic [2*WIDTH-1:0]      result,
    output logic                    busy,
    output logic [WIDTH-1:0]        mul_X,
    output logic [WIDTH-1:0]        mul_Y,
    output logic                    mul_start,
    output logic                    mul_clr,
    input  logic                    mul_ready,
    input  logic [2*WIDTH-1:0]      mul_w
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_ABORT, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [LW-1:0]          last_q, last_d;
    logic [WIDTH-1:0]       mul_x_q, mul_x_d;
    logic [WIDTH-1:0]       mul_y_q, mul_y_d;
    logic [2*WIDTH-1:0]     result_q, result_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   err_pend_q, err_pend_d;
    logic                   win_vld;
    logic [LW-1:0]          win_idx;

    // Rotating priority search starting just after the last winner; the lowest
    // offset is assigned last so it takes precedence.
    function automatic logic [LW:0] pick(input logic [NREQ-1:0] r, input logic [LW-1:0] l);
        int j;
        pick = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j = int'(l) + k;
            if (j >= NREQ) j = j - NREQ;
            if (r[LW'(j)]) pick = {1'b1, LW'(j)};
        end
    endfunction

    assign {win_vld, win_idx} = pick(req, last_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            last_q     <= LAST_RST;
            mul_x_q    <= '0;
            mul_y_q    <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            err_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            mul_x_q    <= mul_x_d;
            mul_y_q    <= mul_y_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
            err_pend_q <= err_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        mul_x_d    = mul_x_q;
        mul_y_d    = mul_y_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        err_pend_d = err_pend_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) err_pend_d = 1'b0;
                if (win_vld) begin
                    state_d = S_ISSUE;
                    last_d  = win_idx;
                    mul_x_d = x_in[win_idx*WIDTH +: WIDTH];
                    mul_y_d = y_in[win_idx*WIDTH +: WIDTH];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_ARM;
            end
            // Timeout is checked before the handshake so an abort wins a same-cycle exit.
            S_ARM: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST)  state_d = S_ABORT;
                else if (!mul_ready)    state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_ABORT;
                end else if (mul_ready) begin
                    result_d = mul_w;
                    state_d  = S_DONE;
                end
            end
            S_ABORT: begin
                result_d   = '0;
                err_pend_d = 1'b1;
                state_d    = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt       = '0;
        done      = '0;
        err       = 1'b0;
        mul_start = 1'b0;
        mul_clr   = 1'b0;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_ISSUE: begin
                gnt       = NREQ'(1) << last_q;
                mul_start = 1'b1;
            end
            S_ABORT: mul_clr = 1'b1;
            S_DONE: begin
                done = NREQ'(1) << last_q;
                err  = err_pend_q;
            end
            default: ;
        endcase
    end

    assign mul_X  = mul_x_q;
    assign mul_Y  = mul_y_q;
    assign result = result_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter: behavioural multiplier model plus a
// scoreboard of expected completions checked whenever done pulses.
module tb_booth_mult_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 6;
    localparam int TO   = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [W-1:0]      xs [NREQ];
    logic [W-1:0]      ys [NREQ];
    logic [NREQ*W-1:0] x_in, y_in;
    logic [NREQ-1:0]   gnt, done;
    logic              err, busy, mul_start, mul_clr;
    logic [2*W-1:0]    result, mul_w;
    logic [W-1:0]      mul_X, mul_Y;
    logic              mul_ready;

    typedef struct { int idx; logic [2*W-1:0] res; logic err; } exp_t;
    exp_t q[$];

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int done_cyc = -10;
    logic stuck = 1'b0;
    int mcnt;
    logic signed [2*W-1:0] prod;

    assign x_in = {xs[3], xs[2], xs[1], xs[0]};
    assign y_in = {ys[3], ys[2], ys[1], ys[0]};

    booth_mult_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .x_in(x_in), .y_in(y_in),
        .gnt(gnt), .done(done), .err(err), .result(result), .busy(busy),
        .mul_X(mul_X), .mul_Y(mul_Y), .mul_start(mul_start), .mul_clr(mul_clr),
        .mul_ready(mul_ready), .mul_w(mul_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sequential multiplier model: 8 cycles of ready=0 after start, clearable.
    assign prod = $signed(mul_X) * $signed(mul_Y);
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_ready <= 1'b1;
            mul_w     <= '0;
            mcnt      <= 0;
        end else if (mul_clr) begin
            mul_ready <= 1'b1;
            mcnt      <= 0;
        end else if (stuck) begin
            mul_ready <= 1'b1;
            mul_w     <= 12'hABC;
        end else if (mul_start) begin
            mul_ready <= 1'b0;
            mcnt      <= 8;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                mul_ready <= 1'b1;
                mul_w     <= prod;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total = total + 1;
        assert (obs === expv) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    always @(negedge clk) begin
        if (done !== '0) begin
            check("gnt_done_excl", 32'(gnt & done), 0);
            if (q.size() == 0) begin
                check("unexpected_done", 32'(done), 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("done_onehot", 32'(done), 32'(1 << e.idx));
                check("result", 32'(result), 32'(e.res));
                check("err", 32'(err), 32'(e.err));
            end
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input logic [2*W-1:0] res, input logic e);
        exp_t x;
        x.idx = idx; x.res = res; x.err = e;
        q.push_back(x);
    endtask

    task automatic wait_gnt(input int idx, output int gcyc);
        int n = 0;
        do begin tick(); n++; end while (gnt == '0 && n < 200);
        check("gnt", 32'(gnt), 32'(1 << idx));
        check("mul_start", 32'(mul_start), 1);
        gcyc = cyc;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 300) begin tick(); n++; end
        check("idle_reached", 32'(q.size() == 0 && !busy), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g, s, n;
        int order [5];
        for (int i = 0; i < NREQ; i++) begin xs[i] = '0; ys[i] = '0; end

        // Reset state
        repeat (3) tick();
        check("rst_ctrl", 32'({gnt, done, err, busy, mul_start, mul_clr}), 0);
        check("rst_data", 32'({mul_X, mul_Y, result}), 0);
        rst = 1'b1;
        tick();

        // 1: single op 5*3
        xs[0] = 6'd5; ys[0] = 6'd3;
        push(0, 12'd15, 1'b0);
        req = 4'b0001;
        wait_gnt(0, g);
        check("t1_mulX", 32'(mul_X), 5);
        check("t1_mulY", 32'(mul_Y), 3);
        req = '0;
        tick();
        check("t1_start_1cyc", 32'({mul_start, gnt}), 0);
        check("t1_busy", 32'(busy), 1);
        wait_idle();

        // 2: signed -7*4
        xs[2] = 6'h39; ys[2] = 6'd4;
        push(2, 12'hFE4, 1'b0);
        req = 4'b0100;
        wait_gnt(2, g);
        req = '0;
        wait_idle();
        tick();
        check("t2_result_held", 32'(result), 32'h0FE4);

        // 3: round robin from fresh reset, extremes of the operand range
        rst = 1'b0; tick(); rst = 1'b1;
        xs[0] = 6'd31; ys[0] = 6'd31;
        xs[1] = 6'h20; ys[1] = 6'h20;
        xs[2] = 6'h20; ys[2] = 6'd31;
        xs[3] = 6'd0;  ys[3] = 6'h3F;
        order = '{0, 1, 2, 3, 0};
        push(0, 12'h3C1, 1'b0);
        push(1, 12'h400, 1'b0);
        push(2, 12'hC20, 1'b0);
        push(3, 12'h000, 1'b0);
        push(0, 12'h3C1, 1'b0);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(order[k], g);
            if (k > 0) check("t3_no_bubble", 32'(g - done_cyc), 1);
        end
        req = '0;
        wait_idle();

        // 4: stuck-ready multiplier ends in a timeout abort
        stuck = 1'b1;
        xs[1] = 6'd7; ys[1] = 6'd7;
        push(1, 12'h000, 1'b1);
        req = 4'b0010;
        wait_gnt(1, s);
        req = '0;
        n = 0;
        while (!mul_clr && n < 200) begin tick(); n++; end
        check("t4_abort_cycle", 32'(cyc - s), 32'(TO + 1));
        tick();
        check("t4_clr_1cyc", 32'(mul_clr), 0);
        check("t4_done_err", 32'({done, err}), 32'({4'b0010, 1'b1}));
        stuck = 1'b0;
        wait_idle();

        // 5: reset in WAIT, then priority restarts at requester 0
        xs[0] = 6'd3;  ys[0] = 6'd3;
        xs[3] = 6'h3F; ys[3] = 6'd17;
        req = 4'b0001;
        wait_gnt(0, g);
        repeat (4) tick();
        check("t5_busy_before", 32'(busy), 1);
        rst = 1'b0;
        #1;
        check("t5_rst_ctrl", 32'({gnt, done, err, busy, mul_start, mul_clr}), 0);
        check("t5_rst_data", 32'({mul_X, mul_Y, result}), 0);
        tick();
        push(0, 12'd9, 1'b0);
        push(3, 12'hFEF, 1'b0);
        rst = 1'b1;
        req = 4'b1001;
        wait_gnt(0, g);
        req = 4'b1000;
        wait_gnt(3, g);
        req = '0;
        wait_idle();

        // 6: owner drops req the cycle after gnt
        xs[1] = 6'd9; ys[1] = 6'h3B;
        push(1, 12'hFD3, 1'b0);
        req = 4'b0010;
        wait_gnt(1, g);
        tick();
        req = '0;
        n = 0;
        while (done == '0 && n < 100) begin tick(); n++; end
        check("t6_done", 32'(done), 32'h2);
        tick();
        check("t6_after_done", 32'({busy, done}), 0);
        repeat (3) tick();
        check("queue_empty", 32'(q.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
